// File: rtl/conway_sequencer.sv
// conway_sequencer: run/stop/step/load generation controller driving the board-wide cell_rst and cell_ena strobes
module conway_sequencer #(
  parameter int PERIOD_W    = 24,
  parameter int GEN_W       = 16,
  parameter int LOAD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_load,
  input  logic                cmd_run,
  input  logic                cmd_stop,
  input  logic                cmd_step,
  input  logic [PERIOD_W-1:0] period,
  input  logic [GEN_W-1:0]    gen_limit,
  input  logic                board_changed,
  output logic                cell_rst,
  output logic                cell_ena,
  output logic [GEN_W-1:0]    generation,
  output logic [2:0]          fsm_state,
  output logic                running,
  output logic                done,
  output logic                stable
);
  localparam int LW = $clog2(LOAD_CYCLES + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, STEP = 3'd3, HALT = 3'd4} state_t;
  state_t              state;
  logic [PERIOD_W-1:0] presc;
  logic [LW-1:0]       load_cnt;
  logic [PERIOD_W-1:0] eff_m1;
  logic [GEN_W-1:0]    gen_inc;
  logic                limit_hit;
  logic                go_load;
  assign eff_m1    = (period == '0) ? '0 : period - 1'b1;
  assign gen_inc   = &generation ? generation : generation + 1'b1;
  assign limit_hit = (gen_limit != '0) && (generation == gen_limit);
  assign go_load   = cmd_load && (state == IDLE || state == RUN || state == HALT);
  assign fsm_state = state;
  assign running   = (state == RUN);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      presc      <= '0;
      load_cnt   <= '0;
      cell_rst   <= 1'b0;
      cell_ena   <= 1'b0;
      generation <= '0;
      done       <= 1'b0;
      stable     <= 1'b0;
    end else begin
      cell_ena <= 1'b0;
      if (go_load) begin
        state      <= LOAD;
        cell_rst   <= 1'b1;
        load_cnt   <= LW'(LOAD_CYCLES - 1);
        generation <= '0;
        done       <= 1'b0;
        stable     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!cmd_stop && cmd_step) begin
              state      <= STEP;
              cell_ena   <= 1'b1;
              generation <= gen_inc;
            end else if (!cmd_stop && cmd_run) begin
              state <= RUN;
              presc <= '0;
            end
          end
          LOAD: begin
            if (load_cnt == '0) begin
              state    <= IDLE;
              cell_rst <= 1'b0;
            end else begin
              load_cnt <= load_cnt - 1'b1;
            end
          end
          STEP: state <= IDLE;
          RUN: begin
            if (cmd_stop) begin
              state <= IDLE;
              presc <= '0;
            end else if (cell_ena && limit_hit) begin
              // limit is judged on the strobe just issued, so the halt follows it
              state <= HALT;
              done  <= 1'b1;
            end else if (presc >= eff_m1) begin
              if (!board_changed) begin
                state  <= HALT;
                stable <= 1'b1;
              end else begin
                cell_ena   <= 1'b1;
                generation <= gen_inc;
                presc      <= '0;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          HALT: begin
            if (cmd_stop) begin
              state  <= IDLE;
              done   <= 1'b0;
              stable <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_conway_sequencer.sv
// tb_conway_sequencer: directed stimulus with a strobe scoreboard checked by a separate monitor
module tb_conway_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_load = 1'b0, cmd_run = 1'b0, cmd_stop = 1'b0, cmd_step = 1'b0;
  logic [23:0] period = '0;
  logic [15:0] gen_limit = '0;
  logic        board_changed = 1'b0;
  logic        cell_rst, cell_ena, running, done, stable;
  logic [15:0] generation;
  logic [2:0]  fsm_state;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  typedef struct {int c; logic [15:0] g;} exp_t;
  exp_t        exp_q[$];
  exp_t        e;

  conway_sequencer dut (
    .clk(clk), .rst(rst), .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
    .cmd_step(cmd_step), .period(period), .gen_limit(gen_limit), .board_changed(board_changed),
    .cell_rst(cell_rst), .cell_ena(cell_ena), .generation(generation), .fsm_state(fsm_state),
    .running(running), .done(done), .stable(stable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, x);
    end
  endtask

  // Monitor: every cell_ena pulse must match the next expected strobe in time and generation
  always @(negedge clk) begin
    if (cell_ena && cell_rst) chk("ena_rst_overlap", 1, 0);
    if (cell_ena) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe_cyc", cyc, 0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cyc", cyc, e.c);
        chk("strobe_gen", {16'h0, generation}, {16'h0, e.g});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic issue(input logic l, input logic r, input logic s, input logic t);
    cmd_load = l; cmd_run = r; cmd_stop = s; cmd_step = t;
    tick();
    cmd_load = 0; cmd_run = 0; cmd_stop = 0; cmd_step = 0;
  endtask

  task automatic push(input int c, input logic [15:0] g);
    exp_q.push_back('{c, g});
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k, n;
    tick(); tick();
    chk("reset_fsm", fsm_state, 0);
    chk("reset_outs", {cell_rst, cell_ena, running, done, stable}, 0);
    chk("reset_gen", generation, 0);
    rst = 1'b1;
    tick();
    // single step from IDLE
    k = cyc; push(k + 1, 16'd1);
    issue(0, 0, 0, 1);
    chk("step_state", fsm_state, 3);
    tick();
    chk("step_back_idle", fsm_state, 0);
    chk("step_gen", generation, 1);
    // load holds cell_rst for two cycles and clears generation
    issue(1, 0, 0, 0);
    chk("load_state", fsm_state, 1);
    chk("load_gen", generation, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (cell_rst) n++;
      tick();
    end
    chk("load_rst_cycles", n, 2);
    chk("load_idle", fsm_state, 0);
    // period 4, limit 3
    period = 24'd4; gen_limit = 16'd3; board_changed = 1'b1;
    k = cyc;
    for (int i = 1; i <= 3; i++) push(k + 1 + 4 * i, 16'(i));
    issue(0, 1, 0, 0);
    chk("run_running", running, 1);
    to_cyc(k + 15);
    chk("limit_gen", generation, 3);
    chk("limit_done", done, 1);
    chk("limit_halt", fsm_state, 4);
    chk("limit_running", running, 0);
    to_cyc(k + 35);
    chk("limit_no_more", exp_q.size(), 0);
    issue(0, 0, 1, 0);
    chk("halt_stop_idle", fsm_state, 0);
    chk("halt_stop_done", done, 0);
    // load and run together: load wins
    issue(1, 1, 0, 0);
    chk("loadrun_state", fsm_state, 1);
    chk("loadrun_gen", generation, 0);
    tick(); tick(); tick();
    chk("loadrun_idle", fsm_state, 0);
    // period 0 behaves as 1; static board halts with stable
    period = '0; gen_limit = '0;
    k = cyc;
    for (int i = 1; i <= 3; i++) push(k + 1 + i, 16'(i));
    issue(0, 1, 0, 0);
    to_cyc(k + 4);
    board_changed = 1'b0;
    to_cyc(k + 6);
    chk("stable_flag", stable, 1);
    chk("stable_halt", fsm_state, 4);
    chk("stable_gen", generation, 3);
    chk("stable_done", done, 0);
    issue(0, 0, 1, 0);
    chk("stable_cleared", stable, 0);
    // mid-run period decrease, then stop
    period = 24'd100; board_changed = 1'b1;
    k = cyc; push(k + 52, 16'd4);
    issue(0, 1, 0, 0);
    to_cyc(k + 10);
    chk("run_state", fsm_state, 2);
    to_cyc(k + 51);
    period = 24'd10;
    to_cyc(k + 55);
    issue(0, 0, 1, 0);
    chk("stop_idle", fsm_state, 0);
    chk("stop_running", running, 0);
    to_cyc(k + 80);
    chk("stop_gen", generation, 4);
    // async reset while cell_ena is high
    period = 24'd1;
    k = cyc;
    push(k + 2, 16'd5); push(k + 3, 16'd6);
    issue(0, 1, 0, 0);
    to_cyc(k + 4);
    chk("pre_reset_ena", cell_ena, 1);
    rst = 1'b0;
    #1;
    chk("async_outs", {cell_rst, cell_ena, running, done, stable}, 0);
    chk("async_gen", generation, 0);
    chk("async_fsm", fsm_state, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_reset_fsm", fsm_state, 0);
    // run to the all-ones generation, then a step must not wrap
    gen_limit = 16'hFFFF;
    k = cyc;
    for (int i = 1; i <= 65535; i++) push(k + 1 + i, 16'(i));
    issue(0, 1, 0, 0);
    to_cyc(k + 65538);
    chk("sat_done", done, 1);
    chk("sat_gen", generation, 16'hFFFF);
    issue(0, 0, 1, 0);
    k = cyc; push(k + 1, 16'hFFFF);
    issue(0, 0, 0, 1);
    tick(); tick();
    chk("sat_step_gen", generation, 16'hFFFF);
    chk("sat_step_idle", fsm_state, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
